// File: rtl/scm_pkg.sv
// Shared types for the SCM 1R/1W port arbiter.
//   addr_t / data_t : default-sized SCM address and word types
//   rsp_state_e     : read response state (idle / holding a response)
//   idx_width()     : width of a requester index, never less than one bit
package scm_pkg;

    localparam int SCM_ADDR_WIDTH = 5;
    localparam int SCM_DATA_WIDTH = 32;

    typedef logic [SCM_ADDR_WIDTH-1:0] addr_t;
    typedef logic [SCM_DATA_WIDTH-1:0] data_t;

    typedef enum logic {
        RSP_IDLE  = 1'b0,
        RSP_VALID = 1'b1
    } rsp_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/scm_1r_1w_port_arbiter_if.sv
// Requester-side and SCM-side signals of the port arbiter.
//   slave  : arbiter view (requests and SCM read data in; grants, response, SCM controls out)
//   master : environment view (requesters plus SCM macro)
// Signal suffixes are from the arbiter's point of view.
interface scm_1r_1w_port_arbiter_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int N_RD       = 2,
    parameter int N_WR       = 2
) ();
    localparam int RIDW = (N_RD > 1) ? $clog2(N_RD) : 1;

    logic [N_RD-1:0]                 rd_req_i;
    logic [N_RD-1:0][ADDR_WIDTH-1:0] rd_addr_i;
    logic [N_RD-1:0]                 rd_gnt_o;
    logic                            rd_rvalid_o;
    logic [RIDW-1:0]                 rd_rid_o;
    logic [DATA_WIDTH-1:0]           rd_rdata_o;
    logic                            rd_rready_i;

    logic [N_WR-1:0]                 wr_req_i;
    logic [N_WR-1:0][ADDR_WIDTH-1:0] wr_addr_i;
    logic [N_WR-1:0][DATA_WIDTH-1:0] wr_data_i;
    logic [N_WR-1:0]                 wr_gnt_o;

    logic                            mem_re_o;
    logic [ADDR_WIDTH-1:0]           mem_raddr_o;
    logic [DATA_WIDTH-1:0]           mem_rdata_i;
    logic                            mem_we_o;
    logic [ADDR_WIDTH-1:0]           mem_waddr_o;
    logic [DATA_WIDTH-1:0]           mem_wdata_o;

    modport slave (
        input  rd_req_i, rd_addr_i, rd_rready_i,
        input  wr_req_i, wr_addr_i, wr_data_i,
        input  mem_rdata_i,
        output rd_gnt_o, rd_rvalid_o, rd_rid_o, rd_rdata_o,
        output wr_gnt_o,
        output mem_re_o, mem_raddr_o, mem_we_o, mem_waddr_o, mem_wdata_o
    );

    modport master (
        output rd_req_i, rd_addr_i, rd_rready_i,
        output wr_req_i, wr_addr_i, wr_data_i,
        output mem_rdata_i,
        input  rd_gnt_o, rd_rvalid_o, rd_rid_o, rd_rdata_o,
        input  wr_gnt_o,
        input  mem_re_o, mem_raddr_o, mem_we_o, mem_waddr_o, mem_wdata_o
    );

endinterface

// File: rtl/scm_rr_arbiter.sv
// Round-robin arbiter for one SCM port.
//   clk, rst : clock, synchronous active-high reset
//   req_i    : request vector
//   en_i     : 0 suppresses the grant and the pointer update
//   gnt_o    : one-hot grant or zero
//   idx_o    : index of the round-robin winner, valid whenever any req_i is set,
//              independent of en_i so the caller can run collision checks on it
module scm_rr_arbiter
    import scm_pkg::*;
#(
    parameter int N = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N-1:0]            req_i,
    input  logic                    en_i,
    output logic [N-1:0]            gnt_o,
    output logic [idx_width(N)-1:0] idx_o
);
    localparam int IW = idx_width(N);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] pos;
    logic          found;

    // Scan from the pointer upward, wrapping at N; first requester wins.
    always_comb begin
        found = 1'b0;
        idx_o = '0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            pos = IW'((int'(ptr_q) + k) % N);
            if (!found && req_i[pos]) begin
                found = 1'b1;
                idx_o = pos;
            end
        end
    end

    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        if (en_i && found) begin
            gnt_o[idx_o] = 1'b1;
            ptr_d        = (int'(idx_o) == N - 1) ? '0 : idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/scm_1r_1w_port_arbiter.sv
// Shares one 1R/1W latch-based SCM between N_RD readers and N_WR writers.
//   clk, rst : clock, synchronous active-high reset
//   bus      : requester handshakes and SCM port controls (slave modport)
// Grants are combinational; mem_* follow the winning requester in the grant cycle.
// The SCM registers its read address, so rd_rdata_o is the SCM output passed
// straight through and stays stable while mem_re_o is low.
//
// Response FSM
//   state     | meaning
//   RSP_IDLE  | no read response outstanding
//   RSP_VALID | rd_rvalid_o high, data for rid_q's last read on rd_rdata_o
module scm_1r_1w_port_arbiter
    import scm_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int N_RD       = 2,
    parameter int N_WR       = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    scm_1r_1w_port_arbiter_if.slave     bus
);
    localparam int RIW = idx_width(N_RD);
    localparam int WIW = idx_width(N_WR);

    logic [RIW-1:0]        rd_idx;
    logic [WIW-1:0]        wr_idx;
    logic [N_RD-1:0]       rd_gnt;
    logic [N_WR-1:0]       wr_gnt;
    logic                  rd_en, wr_en;
    logic                  rd_fire, wr_fire;
    logic                  rsp_hold, wr_blocked, rd_collide;
    logic [ADDR_WIDTH-1:0] rd_cand_addr, wr_cand_addr;
    logic [DATA_WIDTH-1:0] wr_cand_data;

    rsp_state_e            state_q, state_d;
    logic [RIW-1:0]        rid_q, rid_d;
    logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;

    scm_rr_arbiter #(.N(N_RD)) u_rd_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i (bus.rd_req_i),
        .en_i  (rd_en),
        .gnt_o (rd_gnt),
        .idx_o (rd_idx)
    );

    scm_rr_arbiter #(.N(N_WR)) u_wr_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i (bus.wr_req_i),
        .en_i  (wr_en),
        .gnt_o (wr_gnt),
        .idx_o (wr_idx)
    );

    assign rd_cand_addr = bus.rd_addr_i[rd_idx];
    assign wr_cand_addr = bus.wr_addr_i[wr_idx];
    assign wr_cand_data = bus.wr_data_i[wr_idx];

    // A held response reads the SCM word live, so a write to that word would
    // change data the requester has not taken yet.
    assign rsp_hold   = (state_q == RSP_VALID) && !bus.rd_rready_i;
    assign wr_blocked = rsp_hold && (wr_cand_addr == rsp_addr_q);
    assign wr_en      = !rst && !wr_blocked;
    assign wr_fire    = |wr_gnt;

    // Write-first: a read of the word being written waits one cycle and then
    // sees the new value.
    assign rd_collide = wr_fire && (rd_cand_addr == wr_cand_addr);
    assign rd_en      = !rst && !rsp_hold && !rd_collide;
    assign rd_fire    = |rd_gnt;

    always_comb begin
        state_d    = state_q;
        rid_d      = rid_q;
        rsp_addr_d = rsp_addr_q;
        if (rd_fire) begin
            state_d    = RSP_VALID;
            rid_d      = rd_idx;
            rsp_addr_d = rd_cand_addr;
        end else if ((state_q == RSP_VALID) && bus.rd_rready_i) begin
            state_d = RSP_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RSP_IDLE;
            rid_q      <= '0;
            rsp_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            rid_q      <= rid_d;
            rsp_addr_q <= rsp_addr_d;
        end
    end

    assign bus.rd_gnt_o    = rd_gnt;
    assign bus.wr_gnt_o    = wr_gnt;
    assign bus.rd_rvalid_o = (state_q == RSP_VALID);
    assign bus.rd_rid_o    = rid_q;
    assign bus.rd_rdata_o  = bus.mem_rdata_i;

    assign bus.mem_re_o    = rd_fire;
    assign bus.mem_raddr_o = rd_cand_addr;
    assign bus.mem_we_o    = wr_fire;
    assign bus.mem_waddr_o = wr_cand_addr;
    assign bus.mem_wdata_o = wr_cand_data;

endmodule
